// File: rtl/fault_mem_cfg.sv
// Behavioural single-port RAM with one run-time selectable fault, used as the
// device under test for the MBIST controller. Write data is registered one
// cycle ahead of its strobe, reads have a two-stage pipeline, and every fault
// activation is reported by a pulse plus a saturating counter.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
  localparam int DEPTH = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  fault_load,
  input  logic [2:0]            fault_type,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [BIT_W-1:0]      fault_bit,
  input  logic [ADDR_WIDTH-1:0] aggr_addr,
  input  logic [BIT_W-1:0]      aggr_bit,
  output logic                  fault_hit,
  output logic [CNT_WIDTH-1:0]  fault_cnt
);

  typedef enum logic [2:0] {
    FT_NONE, FT_SA0, FT_SA1, FT_TF_UP, FT_TF_DN, FT_CFID_DN, FT_CFID_UP, FT_CFIN
  } fault_t;

  typedef struct packed {
    fault_t                ftype;
    logic [ADDR_WIDTH-1:0] vaddr;
    logic [BIT_W-1:0]      vbit;
    logic [ADDR_WIDTH-1:0] aaddr;
    logic [BIT_W-1:0]      abit;
  } cfg_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  cfg_t                  cfg;
  fault_t                eff;
  logic [DATA_WIDTH-1:0] wreg, rreg, old_w, store, rd_w;
  logic                  rreg_vld;
  logic                  vic_we, vic_val, vic_old, a_old, a_new, hit_c;
  // Last bit value the user wrote into the victim: a stuck-at read counts as a
  // hit when the forced value differs from it (or nothing was written yet).
  logic                  ref_bit, ref_vld;

  // Fault effects on the current access: word to store, victim side-write,
  // corrected read word and the activation flag.
  always_comb begin
    eff = cfg.ftype;
    if (eff >= FT_CFID_DN && cfg.aaddr == cfg.vaddr) eff = FT_NONE;
    old_w   = mem[address];
    vic_old = mem[cfg.vaddr][cfg.vbit];
    store   = wreg;
    rd_w    = old_w;
    vic_we  = 1'b0;
    vic_val = 1'b0;
    hit_c   = 1'b0;
    a_old   = old_w[cfg.abit];
    a_new   = wreg[cfg.abit];
    if (write_read) begin
      if (address == cfg.vaddr) begin
        case (eff)
          FT_SA0: begin store[cfg.vbit] = 1'b0; hit_c = wreg[cfg.vbit]; end
          FT_SA1: begin store[cfg.vbit] = 1'b1; hit_c = !wreg[cfg.vbit]; end
          FT_TF_UP: if (!old_w[cfg.vbit] && wreg[cfg.vbit]) begin
            store[cfg.vbit] = 1'b0;
            hit_c = 1'b1;
          end
          FT_TF_DN: if (old_w[cfg.vbit] && !wreg[cfg.vbit]) begin
            store[cfg.vbit] = 1'b1;
            hit_c = 1'b1;
          end
          default: ;
        endcase
      end
      // aggressor and victim addresses differ here, so only one applies
      if (address == cfg.aaddr) begin
        case (eff)
          FT_CFID_DN: if (a_old && !a_new) begin
            vic_we = 1'b1; vic_val = 1'b0; hit_c = vic_old;
          end
          FT_CFID_UP: if (!a_old && a_new) begin
            vic_we = 1'b1; vic_val = 1'b1; hit_c = !vic_old;
          end
          FT_CFIN: if (a_old != a_new) begin
            vic_we = 1'b1; vic_val = !vic_old; hit_c = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (address == cfg.vaddr) begin
      case (eff)
        FT_SA0: begin rd_w[cfg.vbit] = 1'b0; hit_c = !ref_vld || ref_bit; end
        FT_SA1: begin rd_w[cfg.vbit] = 1'b1; hit_c = !ref_vld || !ref_bit; end
        default: ;
      endcase
    end
  end

  // Array: not reset, and frozen while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (write_read) mem[address] <= store;
      if (vic_we) mem[cfg.vaddr][cfg.vbit] <= vic_val;
    end
  end

  // Write-data register, read pipeline, fault config and activation reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg      <= '0;
      rreg      <= '0;
      rreg_vld  <= 1'b0;
      rdata     <= '0;
      fault_hit <= 1'b0;
      fault_cnt <= '0;
      cfg       <= '{ftype: FT_NONE, default: '0};
      ref_bit   <= 1'b0;
      ref_vld   <= 1'b0;
    end else begin
      wreg     <= wdata;
      rreg_vld <= !write_read;
      if (!write_read) rreg <= rd_w;
      if (rreg_vld) rdata <= rreg;
      fault_hit <= hit_c;
      if (hit_c && fault_cnt != '1) fault_cnt <= fault_cnt + CNT_WIDTH'(1);
      if (write_read && address == cfg.vaddr) begin
        ref_bit <= wreg[cfg.vbit];
        ref_vld <= 1'b1;
      end
      if (fault_load) begin
        cfg <= '{ftype: fault_t'(fault_type), vaddr: fault_addr, vbit: fault_bit,
                 aaddr: aggr_addr, abit: aggr_bit};
        ref_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Directed bench for fault_mem_cfg: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops them and checks fault_hit and rdata.
module tb_fault_mem_cfg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_read = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       fault_load = 1'b0;
  logic [2:0] fault_type = '0;
  logic [3:0] fault_addr = '0;
  logic [2:0] fault_bit = '0;
  logic [3:0] aggr_addr = '0;
  logic [2:0] aggr_bit = '0;
  logic       fault_hit;
  logic [7:0] fault_cnt;

  fault_mem_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata), .fault_load(fault_load),
    .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .aggr_addr(aggr_addr), .aggr_bit(aggr_bit), .fault_hit(fault_hit),
    .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         hit;
    bit         chk;
    logic [7:0] rd;
  } ent_t;

  ent_t q[$];
  int   pass_n = 0;
  int   tot_n  = 0;
  int   ecnt   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock of stimulus; the expectation for that edge is queued at the edge.
  task automatic cyc(input bit we, input logic [3:0] a, input logic [7:0] wd,
                     input bit h, input bit chk, input logic [7:0] rd);
    write_read = we;
    address    = a;
    wdata      = wd;
    @(posedge clk);
    q.push_back('{h, chk, rd});
    if (h && ecnt < 255) ecnt++;
    #1;
    fault_load = 1'b0;
  endtask

  // wdata leads its write strobe by one cycle; the lead cycle reads address 0,
  // which is never a fault target.
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit h);
    cyc(1'b0, 4'd0, d, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, a, d, h, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] d, input bit h);
    cyc(1'b0, a, 8'h00, h, 1'b1, d);
  endtask

  task automatic cfg(input logic [2:0] t, input logic [3:0] fa, input logic [2:0] fb,
                     input logic [3:0] aa, input logic [2:0] ab);
    fault_type = t; fault_addr = fa; fault_bit = fb;
    aggr_addr  = aa; aggr_bit  = ab;
    fault_load = 1'b1;
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: rdata belongs to the read queued one edge earlier.
  ent_t prev = '{1'b0, 1'b0, 8'h00};
  ent_t cur;
  always @(negedge clk) begin
    if (!rst_n || q.size() == 0) begin
      prev.chk = 1'b0;
    end else begin
      cur = q.pop_front();
      check("fault_hit", {31'd0, fault_hit}, {31'd0, cur.hit});
      if (prev.chk) check("rdata", {24'd0, rdata}, {24'd0, prev.rd});
      prev = cur;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_hit", {31'd0, fault_hit}, 32'd0);
    check("rst_cnt", {24'd0, fault_cnt}, 32'd0);
    rst_n = 1'b1;

    // no fault
    wr(4'd3, 8'hA5, 1'b0);
    rd(4'd3, 8'hA5, 1'b0);
    check("t1_cnt", {24'd0, fault_cnt}, 32'd0);

    // SA1 at 5.2: hit on write of 0 and on corrected read
    cfg(3'd2, 4'd5, 3'd2, 4'd0, 3'd0);
    wr(4'd5, 8'h00, 1'b1);
    rd(4'd5, 8'h04, 1'b1);
    check("t2_cnt", {24'd0, fault_cnt}, 32'd2);

    // TF_DN then TF_UP at 7.0
    cfg(3'd4, 4'd7, 3'd0, 4'd0, 3'd0);
    wr(4'd7, 8'hFF, 1'b0);
    wr(4'd7, 8'h00, 1'b1);
    rd(4'd7, 8'h01, 1'b0);
    cfg(3'd3, 4'd7, 3'd0, 4'd0, 3'd0);
    wr(4'd7, 8'h00, 1'b0);
    wr(4'd7, 8'hFF, 1'b1);
    rd(4'd7, 8'hFE, 1'b0);
    check("t3_cnt", {24'd0, fault_cnt}, ecnt);

    // CFID_DN aggr 6.4 -> victim 7.3, then CFID_UP
    cfg(3'd5, 4'd7, 3'd3, 4'd6, 3'd4);
    wr(4'd6, 8'hFF, 1'b0);
    wr(4'd7, 8'hFF, 1'b0);
    wr(4'd6, 8'hEF, 1'b1);
    rd(4'd7, 8'hF7, 1'b0);
    wr(4'd6, 8'hEF, 1'b0);
    rd(4'd6, 8'hEF, 1'b0);
    cfg(3'd6, 4'd7, 3'd3, 4'd6, 3'd4);
    wr(4'd6, 8'hFF, 1'b1);
    rd(4'd7, 8'hFF, 1'b0);
    check("t4_cnt", {24'd0, fault_cnt}, 32'd6);

    // CFIN with aggressor == victim address acts as no fault
    cfg(3'd7, 4'd9, 3'd1, 4'd9, 3'd1);
    wr(4'd9, 8'h00, 1'b0);
    wr(4'd9, 8'hFF, 1'b0);
    rd(4'd9, 8'hFF, 1'b0);
    wr(4'd10, 8'h00, 1'b0);
    // CFIN aggr 10.5 -> victim 9.1
    cfg(3'd7, 4'd9, 3'd1, 4'd10, 3'd5);
    wr(4'd10, 8'h20, 1'b1);
    rd(4'd9, 8'hFD, 1'b0);
    wr(4'd10, 8'h20, 1'b0);
    wr(4'd10, 8'h00, 1'b1);
    rd(4'd9, 8'hFF, 1'b0);
    wr(4'd10, 8'hFF, 1'b1);
    rd(4'd9, 8'hFD, 1'b0);
    rd(4'd10, 8'hFF, 1'b0);
    check("t5_cnt", {24'd0, fault_cnt}, 32'd9);

    // counter saturation with repeated SA0 violations
    cfg(3'd1, 4'd5, 3'd2, 4'd0, 3'd0);
    wr(4'd5, 8'hFF, 1'b1);
    for (int i = 0; i < 260; i++) cyc(1'b1, 4'd5, 8'hFF, 1'b1, 1'b0, 8'h00);
    check("sat_cnt", {24'd0, fault_cnt}, 32'd255);
    rd(4'd5, 8'hFB, 1'b1);
    check("sat_hold", {24'd0, fault_cnt}, 32'd255);

    // reset mid-pipeline with cnt=3
    rst_n = 1'b0;
    #1;
    q.delete();
    ecnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cfg(3'd2, 4'd5, 3'd2, 4'd0, 3'd0);
    wr(4'd5, 8'h00, 1'b1);
    rd(4'd5, 8'h04, 1'b1);
    wr(4'd5, 8'h00, 1'b1);
    check("t6_cnt3", {24'd0, fault_cnt}, 32'd3);
    write_read = 1'b0;
    address    = 4'd5;
    @(posedge clk);
    #1;
    check("t6_hit_pre", {31'd0, fault_hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rdata", {24'd0, rdata}, 32'd0);
    check("t6_rst_hit", {31'd0, fault_hit}, 32'd0);
    check("t6_rst_cnt", {24'd0, fault_cnt}, 32'd0);
    q.delete();
    ecnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr(4'd5, 8'h00, 1'b0);
    rd(4'd5, 8'h00, 1'b0);
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("t6_cnt_end", {24'd0, fault_cnt}, 32'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
